// File: rtl/galaga_pkg.sv
// Shared screen geometry and shot state encoding for the Galaga player logic.
package galaga_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned SHIP_W   = 11;
    localparam int unsigned SHIP_H   = 8;

    // Shot leaves from the middle column of the ship.
    localparam int unsigned SHOT_OFFSET = SHIP_W / 2;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StFly
    } shot_state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for an asynchronous button, plus a one-cycle rising-edge pulse.
module key_sync (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic level,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Metastability chain and edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~prev_q;

endmodule

// File: rtl/player_ctrl.sv
// Player ship movement and single-shot control, updated once per video frame.
module player_ctrl
    import galaga_pkg::*;
#(
    parameter int unsigned X_RESET   = 315,
    parameter int unsigned X_MAX     = SCREEN_W - SHIP_W,
    parameter int unsigned SHIP_Y    = 460,
    parameter int unsigned STEP      = 2,
    parameter int unsigned SHOT_STEP = 4
) (
    input  logic       vgaclk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       keyright,
    input  logic       keyleft,
    input  logic       keyfire,
    output logic [9:0] ship_x,
    output logic [9:0] shot_x,
    output logic [9:0] shot_y,
    output logic       shot_active,
    output logic       frame_tick
);

    logic right_lvl, left_lvl, fire_lvl;
    logic right_rise, left_rise, fire_rise;

    key_sync u_sync_right (
        .clk   (vgaclk),
        .reset (reset),
        .key   (keyright),
        .level (right_lvl),
        .rise  (right_rise)
    );

    key_sync u_sync_left (
        .clk   (vgaclk),
        .reset (reset),
        .key   (keyleft),
        .level (left_lvl),
        .rise  (left_rise)
    );

    key_sync u_sync_fire (
        .clk   (vgaclk),
        .reset (reset),
        .key   (keyfire),
        .level (fire_lvl),
        .rise  (fire_rise)
    );

    // Movement keys act on level, fire acts on edge; the rest is intentionally dropped.
    logic unused_sync;
    assign unused_sync = ^{right_rise, left_rise, fire_lvl};

    logic        vsync_q, vsync_prev_q, frame_tick_q;
    logic        tick;
    logic [9:0]  ship_x_q, ship_x_d;
    logic [9:0]  shot_x_q, shot_x_d;
    logic [9:0]  shot_y_q, shot_y_d;
    logic [10:0] ship_sum;
    shot_state_t state_q, state_d;

    // Game state advances on the same edge that raises frame_tick.
    assign tick = vsync_prev_q & ~vsync_q;

    // Register vsync and emit the frame-start pulse after its falling edge.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            vsync_prev_q <= vsync_q;
            frame_tick_q <= tick;
        end
    end

    // Ship position: saturating step right/left, hold on both or neither.
    always_comb begin
        ship_x_d = ship_x_q;
        ship_sum = {1'b0, ship_x_q} + 11'(STEP);
        if (tick) begin
            if (right_lvl && !left_lvl) begin
                ship_x_d = (ship_sum > 11'(X_MAX)) ? 10'(X_MAX) : ship_sum[9:0];
            end else if (left_lvl && !right_lvl) begin
                ship_x_d = (ship_x_q < 10'(STEP)) ? 10'd0 : ship_x_q - 10'(STEP);
            end
        end
    end

    // Shot FSM next-state: fire arms LAUNCH, launch and flight advance on frame ticks.
    always_comb begin
        state_d  = state_q;
        shot_x_d = shot_x_q;
        shot_y_d = shot_y_q;
        unique case (state_q)
            StIdle: begin
                if (fire_rise) state_d = StLaunch;
            end
            StLaunch: begin
                if (tick) begin
                    state_d  = StFly;
                    shot_x_d = ship_x_q + 10'(SHOT_OFFSET);
                    shot_y_d = 10'(SHIP_Y - SHIP_H);
                end
            end
            StFly: begin
                if (tick) begin
                    if (shot_y_q < 10'(SHOT_STEP)) state_d = StIdle;
                    else shot_y_d = shot_y_q - 10'(SHOT_STEP);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Ship and shot state registers.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            ship_x_q <= 10'(X_RESET);
            shot_x_q <= '0;
            shot_y_q <= '0;
            state_q  <= StIdle;
        end else begin
            ship_x_q <= ship_x_d;
            shot_x_q <= shot_x_d;
            shot_y_q <= shot_y_d;
            state_q  <= state_d;
        end
    end

    assign ship_x      = ship_x_q;
    assign shot_x      = shot_x_q;
    assign shot_y      = shot_y_q;
    assign shot_active = (state_q == StFly);
    assign frame_tick  = frame_tick_q;

endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 Parameter X_RESET, 315: ship left-edge x after reset.
REQ-002 Parameter X_MAX, 629: maximum ship left-edge x (640 - ship width 11).
REQ-003 Parameter SHIP_Y, 460: ship top row, constant.
REQ-004 Parameter STEP, 2: ship pixels moved per frame.
REQ-005 Parameter SHOT_STEP, 4: shot pixels moved up per frame.
REQ-006 Port vgaclk, in, 1: the only clock, 25 MHz pixel clock.
REQ-007 Port reset, in, 1: synchronous, active-high reset.
REQ-008 Port vsync, in, 1: active-low vertical sync from the VGA controller, same clock domain.
REQ-009 Port keyright, in, 1: asynchronous, active-high move-right button.
REQ-010 Port keyleft, in, 1: asynchronous, active-high move-left button.
REQ-011 Port keyfire, in, 1: asynchronous, active-high fire button.
REQ-012 Port ship_x, out, 10: ship left-edge x, consumed by the rocket renderer.
REQ-013 Port shot_x, out, 10: shot column.
REQ-014 Port shot_y, out, 10: shot top row.
REQ-015 Port shot_active, out, 1: shot is to be drawn.
REQ-016 Port frame_tick, out, 1: one-cycle frame-start pulse.

Function
REQ-017 Each key SHALL pass through a two-flop synchronizer before use; key-to-effect latency is 2 cycles plus wait for the next frame_tick.
REQ-018 frame_tick SHALL pulse high for exactly one cycle on the cycle after a registered vsync is seen going 1->0.
REQ-019 ship_x, shot_x, shot_y and shot_active SHALL change only on frame_tick cycles, or on reset.
REQ-020 On frame_tick, with right=1 and left=0, ship_x SHALL become min(ship_x+STEP, X_MAX); the computation has no 10-bit wrap.
REQ-021 On frame_tick, with left=1 and right=0, ship_x SHALL become ship_x-STEP, or 0 if ship_x<STEP.
REQ-022 On frame_tick, with both keys or neither key pressed, ship_x SHALL hold.
REQ-023 Shot FSM states SHALL be IDLE, LAUNCH and FLY.
REQ-024 IDLE->LAUNCH SHALL occur on a synchronized keyfire 0->1 edge; fire edges in LAUNCH or FLY are ignored and not queued.
REQ-025 A fire edge coinciding with frame_tick in IDLE SHALL enter LAUNCH; the launch happens on the following frame_tick, not the same one.
REQ-026 LAUNCH->FLY SHALL occur on frame_tick, loading shot_x=ship_x+5 (using the pre-update ship_x) and shot_y=SHIP_Y-8.
REQ-027 In FLY on frame_tick, if shot_y<SHOT_STEP the FSM SHALL go to IDLE; otherwise shot_y SHALL become shot_y-SHOT_STEP.
REQ-028 shot_active SHALL be 1 exactly while the FSM is in FLY.

Reset
REQ-029 On reset the outputs SHALL be: ship_x=X_RESET, shot_x=0, shot_y=0, shot_active=0, frame_tick=0; FSM=IDLE; synchronizer and edge flops=0.
REQ-030 Reset asserted mid-flight SHALL force IDLE and shot_active=0 on the next vgaclk edge.

Structure
REQ-031 Package galaga_pkg SHALL hold the screen constants (640, 480), ship width 11, ship height 8, and the enum shot_state_t.
REQ-032 Sub-module key_sync (two-flop synchronizer plus rising-edge pulse) SHALL be instantiated three times.

Verification
REQ-033 Reset -> ship_x=315, shot_active=0, frame_tick=0.
REQ-034 keyright held for 3 frames -> ship_x=321; keyleft from ship_x=1 -> ship_x=0.
REQ-035 ship_x=628 with keyright -> ship_x=629, and it holds at 629 on subsequent ticks.
REQ-036 Both keys held for 5 frames -> ship_x unchanged.
REQ-037 keyfire pulse at ship_x=315 -> next tick gives shot_x=320, shot_y=452, shot_active=1; after 113 further ticks shot_y=0; the next tick gives shot_active=0.
REQ-038 Second keyfire during FLY -> no effect; reset during FLY -> shot_active=0 the following cycle.
